// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Five-stage pipeline stall/bubble controller with stall statistics and data-bus watchdog
module pipe_hazard_ctrl #(
    parameter logic [5:0] LW_ICODE   = 6'h23,
    parameter int         WAIT_LIMIT = 1024,
    parameter int         CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       d_src1,
    input  logic [4:0]       d_src2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             d_jump,
    input  logic [5:0]       e_icode,
    input  logic [4:0]       e_dst,
    input  logic [5:0]       m_icode,
    input  logic [4:0]       m_dst,
    input  logic             i_busy,
    input  logic             d_busy,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             E_bubble,
    output logic             M_stall,
    output logic             W_bubble,
    output logic             redir_pend,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] ldu_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic             wd_err
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LDUSE = 2'd1,
        IWAIT = 2'd2,
        DWAIT = 2'd3
    } state_t;

    localparam int               WD_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             redir_q, redir_d;
    logic [CNT_W-1:0] ldu_cnt_q, ldu_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             wd_err_q, wd_err_d;

    logic hz1, hz2, ldu;
    logic f_stall_c, d_stall_c, e_stall_c, e_bubble_c, m_stall_c, w_bubble_c;

    // A load still in M only matters while its data access is outstanding.
    assign hz1 = d_use1 && (d_src1 != 5'd0) &&
                 (((e_icode == LW_ICODE) && (e_dst == d_src1)) ||
                  ((m_icode == LW_ICODE) && (m_dst == d_src1) && d_busy));
    assign hz2 = d_use2 && (d_src2 != 5'd0) &&
                 (((e_icode == LW_ICODE) && (e_dst == d_src2)) ||
                  ((m_icode == LW_ICODE) && (m_dst == d_src2) && d_busy));
    assign ldu = hz1 || hz2;

    always_comb begin
        state_d    = RUN;
        f_stall_c  = 1'b0;
        d_stall_c  = 1'b0;
        e_stall_c  = 1'b0;
        e_bubble_c = 1'b0;
        m_stall_c  = 1'b0;
        w_bubble_c = 1'b0;
        if (d_busy) begin
            state_d    = DWAIT;
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_stall_c  = 1'b1;
            m_stall_c  = 1'b1;
            w_bubble_c = 1'b1;
        end else if (ldu) begin
            state_d    = LDUSE;
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_bubble_c = 1'b1;
        end else if (i_busy) begin
            state_d    = IWAIT;
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_bubble_c = 1'b1;
        end
    end

    always_comb begin
        ldu_cnt_d = ldu_cnt_q;
        mem_cnt_d = mem_cnt_q;
        if ((state_d == LDUSE) && (ldu_cnt_q != CNT_MAX)) begin
            ldu_cnt_d = ldu_cnt_q + CNT_W'(1);
        end
        if (((state_d == DWAIT) || (state_d == IWAIT)) && (mem_cnt_q != CNT_MAX)) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end

        wd_cnt_d = '0;
        if (d_busy) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
        end
        wd_err_d = wd_err_q || (wd_cnt_d == WD_MAX);

        // Set needs F_stall=1 and clear needs F_stall=0, so they never collide.
        redir_d = redir_q;
        if (d_jump && f_stall_c) begin
            redir_d = 1'b1;
        end else if (!f_stall_c) begin
            redir_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RUN;
            redir_q   <= 1'b0;
            ldu_cnt_q <= '0;
            mem_cnt_q <= '0;
            wd_cnt_q  <= '0;
            wd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            redir_q   <= redir_d;
            ldu_cnt_q <= ldu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
            wd_err_q  <= wd_err_d;
        end
    end

    assign F_stall    = resetn && f_stall_c;
    assign D_stall    = resetn && d_stall_c;
    assign E_stall    = resetn && e_stall_c;
    assign E_bubble   = resetn && e_bubble_c;
    assign M_stall    = resetn && m_stall_c;
    assign W_bubble   = resetn && w_bubble_c;
    assign redir_pend = redir_q;
    assign state      = state_q;
    assign ldu_cnt    = ldu_cnt_q;
    assign mem_cnt    = mem_cnt_q;
    assign wd_err     = wd_err_q;

endmodule
